// File: rtl/bit_reverse_stream_buffer.sv
// ---------------------------------------------------------------------------
// bit_reverse_stream_buffer
//
// Ping-pong reorder buffer for frames of N = 2^LOG_N samples. The write side
// fills one bank in natural order while the read side drains the other bank
// in bit-reversed order (or in natural order when the frame was started with
// in_bypass high). Sustains one sample per cycle on each side.
//
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both high. in_ready and out_valid come from registered state only;
// out_data and out_last are held steady while out_valid is high and
// out_ready is low.
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst        asynchronous, active-high reset
//   in_valid   input sample present
//   in_ready   buffer can accept an input sample
//   in_data    input sample, natural order
//   in_bypass  frame mode, sampled with the first sample of each frame
//   out_valid  output sample present
//   out_ready  downstream accepts the output sample
//   out_data   reordered sample (0 when out_valid is low)
//   out_last   high with the final sample of each output frame
// ---------------------------------------------------------------------------
module bit_reverse_stream_buffer #(
    parameter int DATA_W = 8,
    parameter int LOG_N  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_bypass,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last
);

    localparam int N = 1 << LOG_N;
    localparam logic [LOG_N-1:0] CNT_LAST = {LOG_N{1'b1}};

    // Sample storage; contents are never reset.
    logic [DATA_W-1:0] r_mem0 [N];
    logic [DATA_W-1:0] r_mem1 [N];

    logic             r_wr_bank;
    logic             r_rd_bank;
    logic [LOG_N-1:0] r_wr_cnt;
    logic [LOG_N-1:0] r_rd_cnt;
    logic [1:0]       r_full;
    logic [1:0]       r_byp;

    logic              w_in_fire;
    logic              w_out_fire;
    logic              w_wr_last;
    logic              w_rd_last;
    logic [LOG_N-1:0]  w_rev_cnt;
    logic [LOG_N-1:0]  w_rd_idx;
    logic [DATA_W-1:0] w_rd_word;

    assign in_ready   = !r_full[r_wr_bank];
    assign out_valid  = r_full[r_rd_bank];

    assign w_in_fire  = in_valid && in_ready;
    assign w_out_fire = out_valid && out_ready;
    assign w_wr_last  = (r_wr_cnt == CNT_LAST);
    assign w_rd_last  = (r_rd_cnt == CNT_LAST);

    // Reverse the read counter bits to get the bit-reversed read address.
    always_comb begin
        w_rev_cnt = '0;
        for (int i = 0; i < LOG_N; i++) begin
            w_rev_cnt[i] = r_rd_cnt[LOG_N-1-i];
        end
    end

    assign w_rd_idx  = r_byp[r_rd_bank] ? r_rd_cnt : w_rev_cnt;
    assign w_rd_word = r_rd_bank ? r_mem1[w_rd_idx] : r_mem0[w_rd_idx];

    assign out_data  = out_valid ? w_rd_word : '0;
    assign out_last  = out_valid && w_rd_last;

    // Storage write port.
    always_ff @(posedge clk) begin
        if (w_in_fire) begin
            if (r_wr_bank) begin
                r_mem1[r_wr_cnt] <= in_data;
            end else begin
                r_mem0[r_wr_cnt] <= in_data;
            end
        end
    end

    // Bank bookkeeping. The write side only ever targets a bank that is not
    // full and the read side only clears a full bank, so the set and clear of
    // r_full below never hit the same bit in one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_bank <= 1'b0;
            r_rd_bank <= 1'b0;
            r_wr_cnt  <= '0;
            r_rd_cnt  <= '0;
            r_full    <= 2'b00;
            r_byp     <= 2'b00;
        end else begin
            if (w_in_fire) begin
                if (r_wr_cnt == '0) begin
                    r_byp[r_wr_bank] <= in_bypass;
                end
                if (w_wr_last) begin
                    r_full[r_wr_bank] <= 1'b1;
                    r_wr_bank         <= !r_wr_bank;
                    r_wr_cnt          <= '0;
                end else begin
                    r_wr_cnt <= r_wr_cnt + 1'b1;
                end
            end
            if (w_out_fire) begin
                if (w_rd_last) begin
                    r_full[r_rd_bank] <= 1'b0;
                    r_rd_bank         <= !r_rd_bank;
                    r_rd_cnt          <= '0;
                end else begin
                    r_rd_cnt <= r_rd_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_bit_reverse_stream_buffer.sv
// ---------------------------------------------------------------------------
// tb_bit_reverse_stream_buffer
//
// Directed bench for the reorder buffer: an 8-point instance (dut_a) for the
// directed scenarios and a 16-point instance (dut_b) for a random-stall run.
// Inputs are driven on the falling edge, outputs sampled 1 ns later.
// ---------------------------------------------------------------------------
module tb_bit_reverse_stream_buffer;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // ---------------- DUT A: N = 8 ----------------
    logic       a_in_valid = 1'b0;
    logic       a_in_ready;
    logic [7:0] a_in_data = '0;
    logic       a_in_bypass = 1'b0;
    logic       a_out_valid;
    logic       a_out_ready = 1'b0;
    logic [7:0] a_out_data;
    logic       a_out_last;

    bit_reverse_stream_buffer #(.DATA_W(8), .LOG_N(3)) dut_a (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .in_data   (a_in_data),
        .in_bypass (a_in_bypass),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .out_data  (a_out_data),
        .out_last  (a_out_last)
    );

    // ---------------- DUT B: N = 16 ----------------
    logic       b_in_valid = 1'b0;
    logic       b_in_ready;
    logic [7:0] b_in_data = '0;
    logic       b_in_bypass = 1'b0;
    logic       b_out_valid;
    logic       b_out_ready = 1'b0;
    logic [7:0] b_out_data;
    logic       b_out_last;

    bit_reverse_stream_buffer #(.DATA_W(8), .LOG_N(4)) dut_b (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .in_data   (b_in_data),
        .in_bypass (b_in_bypass),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out_data  (b_out_data),
        .out_last  (b_out_last)
    );

    // ---------------- scoreboard state ----------------
    int n_vec  = 0;
    int n_miss = 0;

    logic [7:0] exp_q[$];
    logic       exp_last_q[$];
    logic [7:0] got_q[$];
    logic       got_last_q[$];

    // Hand-computed bit-reversal tables.
    logic [7:0] br8  [8]  = '{0, 4, 2, 6, 1, 5, 3, 7};
    logic [7:0] br16 [16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};

    // Values sampled during the most recent cyc_a call.
    logic s_in_ready;
    logic s_out_valid;
    logic a_acc;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks for dut_a ----------------
    task automatic cyc_a(input logic v, input logic [7:0] d, input logic byp, input logic rdy);
        @(negedge clk);
        a_in_valid  = v;
        a_in_data   = d;
        a_in_bypass = byp;
        a_out_ready = rdy;
        #1;
        s_in_ready  = a_in_ready;
        s_out_valid = a_out_valid;
        a_acc       = v && a_in_ready;
        if (a_out_valid && rdy) begin
            got_q.push_back(a_out_data);
            got_last_q.push_back(a_out_last);
        end
    endtask

    task automatic drain_a(input int n);
        int guard;
        guard = 0;
        while (got_q.size() < n && guard < 100) begin
            cyc_a(1'b0, 8'd0, 1'b0, 1'b1);
            guard++;
        end
    endtask

    task automatic push_exp(input logic [7:0] v);
        exp_last_q.push_back((exp_q.size() % 8) == 7);
        exp_q.push_back(v);
    endtask

    task automatic compare_a(input string tag);
        check_val({tag, "_count"}, got_q.size(), exp_q.size());
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            check_val({tag, "_data"}, got_q.pop_front(), exp_q.pop_front());
            check_val({tag, "_last"}, got_last_q.pop_front(), exp_last_q.pop_front());
        end
        got_q.delete();
        got_last_q.delete();
        exp_q.delete();
        exp_last_q.delete();
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int cnt;
        int guard;
        int valid_run;
        int sent;
        int recv;
        int k;
        logic fbyp;
        logic [7:0] frame [16];
        logic v;
        logic rdy;
        logic byp;
        logic [7:0] d;

        // Reset state
        #12;
        check_val("rst_in_ready",  a_in_ready,  1);
        check_val("rst_out_valid", a_out_valid, 0);
        check_val("rst_out_data",  a_out_data,  0);
        check_val("rst_out_last",  a_out_last,  0);
        check_val("rst_b_in_ready", b_in_ready, 1);
        @(negedge clk);
        rst = 1'b0;

        // Bit-reverse, inputs 0..7
        for (int i = 0; i < 8; i++) cyc_a(1'b1, 8'(i), 1'b0, 1'b1);
        drain_a(8);
        for (int i = 0; i < 8; i++) push_exp(br8[i]);
        compare_a("bitrev");

        // Bypass frame then reversed frame with mid-frame bypass toggle
        for (int i = 0; i < 8; i++) cyc_a(1'b1, 8'(10 + i), 1'b1, 1'b1);
        for (int i = 0; i < 8; i++) cyc_a(1'b1, 8'(20 + i), (i >= 3), 1'b1);
        drain_a(16);
        for (int i = 0; i < 8; i++) push_exp(8'(10 + i));
        push_exp(20); push_exp(24); push_exp(22); push_exp(26);
        push_exp(21); push_exp(25); push_exp(23); push_exp(27);
        compare_a("bypass");

        // Backpressure: out_ready low, in_valid high
        cnt = 0;
        for (int i = 0; i < 24; i++) begin
            cyc_a(1'b1, 8'(cnt), 1'b0, 1'b0);
            if (a_acc) cnt++;
        end
        check_val("bp_accepted", cnt, 16);
        check_val("bp_in_ready_low", s_in_ready, 0);
        guard = 0;
        while (got_q.size() < 8 && guard < 40) begin
            cyc_a(1'b0, 8'd0, 1'b0, 1'b1);
            guard++;
        end
        check_val("bp_ready_at_8th", s_in_ready, 0);
        cyc_a(1'b0, 8'd0, 1'b0, 1'b1);
        check_val("bp_ready_after_8th", s_in_ready, 1);
        drain_a(16);
        for (int i = 0; i < 8; i++) push_exp(br8[i]);
        for (int i = 0; i < 8; i++) push_exp(8'(8 + br8[i]));
        compare_a("bp");

        // Streaming: 4 back-to-back frames
        valid_run = 0;
        for (int c = 0; c < 48; c++) begin
            cyc_a((c < 32), 8'(64 + c), 1'b0, 1'b1);
            if (c == 7) check_val("stream_no_early_valid", s_out_valid, 0);
            if (c == 8) check_val("stream_first_valid", s_out_valid, 1);
            if (c >= 8 && c < 40 && s_out_valid) valid_run++;
        end
        check_val("stream_gapless", valid_run, 32);
        for (int f = 0; f < 4; f++)
            for (int i = 0; i < 8; i++) push_exp(8'(64 + 8 * f + br8[i]));
        compare_a("stream");

        // Reset mid-operation
        for (int i = 0; i < 8; i++) cyc_a(1'b1, 8'(i), 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) cyc_a(1'b1, 8'(30 + i), 1'b0, 1'b1);
        check_val("mid_pre_valid", s_out_valid, 1);
        @(negedge clk);
        a_in_valid  = 1'b0;
        a_out_ready = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check_val("mid_rst_out_valid", a_out_valid, 0);
        check_val("mid_rst_in_ready",  a_in_ready,  1);
        check_val("mid_rst_out_data",  a_out_data,  0);
        @(posedge clk);
        @(negedge clk);
        #1;
        rst = 1'b0;
        got_q.delete();
        got_last_q.delete();
        for (int i = 0; i < 8; i++) cyc_a(1'b1, 8'(i), 1'b0, 1'b1);
        drain_a(8);
        for (int i = 0; i < 8; i++) push_exp(br8[i]);
        compare_a("post_rst");

        // LOG_N = 4, random stalls over 20 frames
        sent = 0;
        recv = 0;
        k = 0;
        fbyp = 1'b0;
        guard = 0;
        while (recv < 320 && guard < 6000) begin
            @(negedge clk);
            v   = (sent < 320) && ($urandom_range(0, 3) != 0);
            d   = 8'($urandom_range(0, 255));
            byp = 1'($urandom_range(0, 1));
            rdy = ($urandom_range(0, 3) != 0);
            b_in_valid  = v;
            b_in_data   = d;
            b_in_bypass = byp;
            b_out_ready = rdy;
            #1;
            if (b_out_valid && rdy) begin
                if (exp_q.size() == 0) begin
                    check_val("rnd_unexpected_out", 1, 0);
                end else begin
                    check_val("rnd_data", b_out_data, exp_q.pop_front());
                    check_val("rnd_last", b_out_last, exp_last_q.pop_front());
                end
                recv++;
            end
            if (v && b_in_ready) begin
                if (k == 0) fbyp = byp;
                frame[k] = d;
                k++;
                sent++;
                if (k == 16) begin
                    for (int j = 0; j < 16; j++) begin
                        exp_q.push_back(fbyp ? frame[j] : frame[br16[j]]);
                        exp_last_q.push_back(j == 15);
                    end
                    k = 0;
                end
            end
            guard++;
        end
        @(negedge clk);
        b_in_valid  = 1'b0;
        b_out_ready = 1'b0;
        check_val("rnd_recv_count", recv, 320);
        check_val("rnd_exp_left", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/bit_reverse_stream_buffer.md
# bit_reverse_stream_buffer

Streaming ping-pong reorder buffer that converts natural-order frames of N = 2^LOG_N samples into bit-reversed order, or passes them through in natural order, at one sample per cycle. It is the parametrised, sequential successor to the fixed 8-point combinational reorder stage. It sits between the sample source and the NTT butterfly pipeline, with valid/ready handshakes on both sides.

## Interface
- DATA_W, 8, sample width in bits
- LOG_N, 3, log2 of frame length; N = 2^LOG_N, legal range 1..10
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset; asynchronous, active-high
- in_valid  in  1  input sample present
- in_ready  out  1  buffer can accept an input sample
- in_data  in  DATA_W  input sample, natural order
- in_bypass  in  1  frame mode, sampled with the first sample of each frame; 1 selects natural-order output
- out_valid  out  1  output sample present
- out_ready  in  1  downstream accepts the output sample
- out_data  out  DATA_W  reordered sample
- out_last  out  1  high with the final (N-th) sample of each output frame

## Operation
- Storage: two banks of N x DATA_W registers, bank0 and bank1. Memory contents are not reset.
- Write side state: wr_bank (1 bit), wr_cnt (LOG_N bits). Read side state: rd_bank (1 bit), rd_cnt (LOG_N bits). Per-bank state: full[b] and byp[b].
- in_ready = !full[wr_bank].
- Input accept (in_valid & in_ready):
  - write mem[wr_bank][wr_cnt] = in_data;
  - if wr_cnt == 0, latch byp[wr_bank] = in_bypass;
  - if wr_cnt == N-1, set full[wr_bank], toggle wr_bank, and wrap wr_cnt to 0; otherwise increment wr_cnt.
- out_valid = full[rd_bank].
- Read index: idx = byp[rd_bank] ? rd_cnt : bitrev(rd_cnt), where bitrev reverses the LOG_N index bits.
- out_data = mem[rd_bank][idx] when out_valid is high; 0 otherwise.
- out_last = out_valid & (rd_cnt == N-1).
- Output accept (out_valid & out_ready):
  - if rd_cnt == N-1, clear full[rd_bank], toggle rd_bank, and wrap rd_cnt to 0;
  - otherwise increment rd_cnt.
- Simultaneous events:
  - Setting full on one bank and clearing full on the other in the same cycle are independent and both take effect.
  - Setting and clearing the same bank in the same cycle cannot occur: the write side never targets a full bank.
- in_bypass is ignored except on the first sample of a frame. Mode changes mid-frame have no effect.
- in_data is ignored when in_valid or in_ready is low.
- Reset (asynchronous, any time):
  - clears wr_bank, rd_bank, wr_cnt, rd_cnt, full[1:0] and byp[1:0];
  - partially written or partially read frames are discarded;
  - the first sample accepted after reset starts a new frame in bank0.
- Reset values: in_ready = 1, out_valid = 0, out_data = 0, out_last = 0.

## Timing
- Input and output paths each sustain one sample per cycle.
- Latency: the last sample of a frame is accepted at edge t. out_valid rises in the cycle after edge t, and the first reordered sample is available immediately.
- With both sides always ready, output is gapless and lags input by N cycles.
- Backpressure:
  - With out_ready held low, the buffer accepts exactly 2N samples, then in_ready falls.
  - in_ready returns high in the cycle after the read side consumes the last sample of a bank.
- in_ready and out_valid depend only on registered state, with no combinational path from in_valid or out_ready.
- out_data and out_last are combinational from registered state and stable while out_valid is high and out_ready is low.

## Test plan
- Bit-reverse, N=8, in_bypass=0: inputs 0..7 -> outputs 0,4,2,6,1,5,3,7, with out_last only on the sample 7.
- Bypass: frame 0 with in_bypass=1, frame 1 with in_bypass=0 (toggle in_bypass mid-frame 1), inputs 10..17 then 20..27.
  - Frame 0 -> 10..17 in natural order.
  - Frame 1 -> 20,24,22,26,21,25,23,27.
- Backpressure: out_ready=0, in_valid=1 continuously.
  - Exactly 16 samples accepted, then in_ready=0.
  - Raise out_ready: in_ready returns high in the cycle after the 8th output.
  - No sample is lost or duplicated.
- Streaming: 4 back-to-back frames with out_ready=1.
  - First out_valid in the cycle after the 8th input.
  - 32 consecutive outputs with no bubbles.
  - Each frame correctly bit-reversed.
- Reset mid-operation: assert rst after 5 inputs of frame 1 while frame 0 is half read.
  - Immediately out_valid=0, in_ready=1, out_data=0.
  - The next 8 inputs 0..7 produce 0,4,2,6,1,5,3,7.
- LOG_N=4 random stalls: random in_valid/out_ready over 20 frames; scoreboard matches 4-bit bit-reversed order and out_last positions.
